// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// State encoding, default sizes and a one-hot to index converter.
package arb_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_IDW  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Inputs are one-hot (or zero), so OR-ing the set positions yields the index.
    function automatic logic [2:0] onehot_to_index(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Request/grant bundle between the requesting masters and the arbiter.
// The master modport drives requests; the slave modport returns grants.
interface bus_rr_arbiter_if #(
    parameter int NREQ = arb_pkg::DEF_NREQ,
    parameter int IDW  = arb_pkg::DEF_IDW
);

    logic [NREQ-1:0] REQ;
    logic [NREQ-1:0] LOCK;
    logic            DONE;
    logic [NREQ-1:0] GNT;
    logic            GNT_VALID;
    logic [IDW-1:0]  GNT_ID;
    logic            TIMEOUT;

    modport master (
        output REQ,
        output LOCK,
        output DONE,
        input  GNT,
        input  GNT_VALID,
        input  GNT_ID,
        input  TIMEOUT
    );

    modport slave (
        input  REQ,
        input  LOCK,
        input  DONE,
        output GNT,
        output GNT_VALID,
        output GNT_ID,
        output TIMEOUT
    );

endinterface

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational round-robin winner selection.
// Searches req from ptr upward, wrapping at NREQ, and reports the first hit.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = DEF_IDW
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] win,
    output logic [IDW-1:0]  win_id,
    output logic            any
);

    logic           found;
    logic [IDW-1:0] k;

    always_comb begin
        win   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = IDW'((int'(ptr) + i) % NREQ);
            if (!found && req[k]) begin
                win[k] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign win_id = IDW'(onehot_to_index(8'(win)));
    assign any    = |req;

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter granting one shared resource to NREQ requesters.
// Optional watchdog release is built only when ARB_TIMEOUT_EN is defined.
module bus_rr_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ       = DEF_NREQ,
    parameter int IDW        = DEF_IDW,
    parameter int TMO_CYCLES = 255
) (
    input logic            CLK,
    input logic            NRESET,
    bus_rr_arbiter_if.slave bus
);

    state_t          state_q;
    state_t          state_d;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] gnt_d;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  id_d;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;
    logic [IDW-1:0]  ptr_next;
    logic            valid_q;

    logic [NREQ-1:0] win;
    logic [IDW-1:0]  win_id;
    logic            any;

    logic            cur_req;
    logic            cur_lock;
    logic            expired;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (bus.REQ),
        .ptr    (ptr_q),
        .win    (win),
        .win_id (win_id),
        .any    (any)
    );

    assign cur_req  = bus.REQ[id_q];
    assign cur_lock = bus.LOCK[id_q];
    assign ptr_next = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    gnt_d   = win;
                    id_d    = win_id;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.DONE && cur_lock && cur_req) begin
                    state_d = BUSY;
                end else if (bus.DONE || (cur_req && expired)) begin
                    gnt_d   = '0;
                    id_d    = '0;
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end else if (!cur_req) begin
                    // Withdrawal keeps the pointer so the requester is not penalised.
                    gnt_d   = '0;
                    id_d    = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                id_d    = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge NRESET) begin
        if (!NRESET) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            valid_q <= |gnt_d;
        end
    end

    assign bus.GNT       = gnt_q;
    assign bus.GNT_VALID = valid_q;
    assign bus.GNT_ID    = id_q;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tmo_q;

    assign expired = (state_q == BUSY) && (cnt_q == CW'(TMO_CYCLES - 1));

    // Idle holds the count at zero, so entry to BUSY always starts fresh.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE || bus.DONE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge NRESET) begin
        if (!NRESET) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= expired && cur_req && !bus.DONE;
        end
    end

    assign bus.TIMEOUT = tmo_q;
`else
    logic unused_tmo;

    assign expired     = 1'b0;
    assign unused_tmo  = ^TMO_CYCLES;
    assign bus.TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed testbench for bus_rr_arbiter (4 requesters).
// Watchdog scenario runs when ARB_TIMEOUT_EN is defined, else a long hold.
module tb_bus_rr_arbiter;

    logic CLK;
    logic NRESET;
    int   checks;
    int   errors;

    bus_rr_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

    bus_rr_arbiter #(
        .NREQ       (4),
        .IDW        (2),
        .TMO_CYCLES (8)
    ) dut (
        .CLK    (CLK),
        .NRESET (NRESET),
        .bus    (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {GNT, GNT_VALID, GNT_ID, TIMEOUT}
    function automatic logic [7:0] snap();
        return {bus.GNT, bus.GNT_VALID, bus.GNT_ID, bus.TIMEOUT};
    endfunction

    task automatic test_reset();
        logic [7:0] obs;
        NRESET   = 1'b0;
        bus.REQ  = '0;
        bus.LOCK = '0;
        bus.DONE = 1'b0;
        repeat (2) @(negedge CLK);
        obs = snap();
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got %b want %b", obs, 8'h00);
        end
        NRESET = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            obs = snap();
            checks++;
            if (obs !== 8'h00) begin
                errors++;
                $display("FAIL idle_noreq cyc %0d got %b want %b", i, obs, 8'h00);
            end
        end
    endtask

    task automatic test_rotate();
        logic [7:0] obs;
        logic [7:0] exp;
        bus.REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp = {4'b0001 << (k % 4), 1'b1, 2'(k % 4), 1'b0};
            @(negedge CLK);
            obs = snap();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rot_gnt %0d got %b want %b", k, obs, exp);
            end
            @(negedge CLK);
            obs = snap();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rot_hold %0d got %b want %b", k, obs, exp);
            end
            bus.DONE = 1'b1;
            @(negedge CLK);
            bus.DONE = 1'b0;
            if (k == 4) bus.REQ = 4'b0000;
            obs = snap();
            checks++;
            if (obs !== 8'h00) begin
                errors++;
                $display("FAIL rot_gap %0d got %b want %b", k, obs, 8'h00);
            end
        end
    endtask

    task automatic test_lock();
        logic [7:0] obs;
        bus.REQ  = 4'b0001;
        bus.LOCK = 4'b0001;
        @(negedge CLK);
        obs = snap();
        checks++;
        if (obs !== 8'b0001_1_00_0) begin
            errors++;
            $display("FAIL lock_gnt got %b want %b", obs, 8'b0001_1_00_0);
        end
        bus.REQ = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            bus.DONE = 1'b1;
            @(negedge CLK);
            bus.DONE = 1'b0;
            obs = snap();
            checks++;
            if (obs !== 8'b0001_1_00_0) begin
                errors++;
                $display("FAIL lock_hold %0d got %b want %b", i, obs, 8'b0001_1_00_0);
            end
        end
        bus.LOCK = 4'b0000;
        bus.DONE = 1'b1;
        @(negedge CLK);
        bus.DONE = 1'b0;
        obs = snap();
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL lock_release got %b want %b", obs, 8'h00);
        end
        @(negedge CLK);
        obs = snap();
        checks++;
        if (obs !== 8'b0100_1_10_0) begin
            errors++;
            $display("FAIL lock_next got %b want %b", obs, 8'b0100_1_10_0);
        end
    endtask

    task automatic test_withdraw();
        logic [7:0] obs;
        bus.REQ = 4'b0000;
        @(negedge CLK);
        obs = snap();
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL wd_drop got %b want %b", obs, 8'h00);
        end
        bus.REQ = 4'b0101;
        @(negedge CLK);
        obs = snap();
        checks++;
        if (obs !== 8'b0100_1_10_0) begin
            errors++;
            $display("FAIL wd_regrant got %b want %b", obs, 8'b0100_1_10_0);
        end
        bus.DONE = 1'b1;
        bus.REQ  = 4'b0000;
        @(negedge CLK);
        bus.DONE = 1'b0;
        obs = snap();
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL wd_done got %b want %b", obs, 8'h00);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] obs;
        bus.REQ = 4'b1000;
        @(negedge CLK);
        obs = snap();
        checks++;
        if (obs !== 8'b1000_1_11_0) begin
            errors++;
            $display("FAIL rst_pre got %b want %b", obs, 8'b1000_1_11_0);
        end
        #2 NRESET = 1'b0;
        #1;
        obs = snap();
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL rst_async got %b want %b", obs, 8'h00);
        end
        @(negedge CLK);
        NRESET  = 1'b1;
        bus.REQ = 4'b1001;
        @(negedge CLK);
        obs = snap();
        checks++;
        if (obs !== 8'b0001_1_00_0) begin
            errors++;
            $display("FAIL rst_ptr0 got %b want %b", obs, 8'b0001_1_00_0);
        end
        bus.DONE = 1'b1;
        bus.REQ  = 4'b1000;
        @(negedge CLK);
        bus.DONE = 1'b0;
        obs = snap();
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL rst_gap got %b want %b", obs, 8'h00);
        end
        @(negedge CLK);
        obs = snap();
        checks++;
        if (obs !== 8'b1000_1_11_0) begin
            errors++;
            $display("FAIL rst_req3 got %b want %b", obs, 8'b1000_1_11_0);
        end
    endtask

    task automatic test_idle_done();
        logic [7:0] obs;
        bus.DONE = 1'b1;
        bus.REQ  = 4'b0000;
        @(negedge CLK);
        @(negedge CLK);
        bus.DONE = 1'b0;
        obs = snap();
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL idle_done got %b want %b", obs, 8'h00);
        end
        bus.REQ = 4'b0010;
        @(negedge CLK);
        obs = snap();
        checks++;
        if (obs !== 8'b0010_1_01_0) begin
            errors++;
            $display("FAIL wrap_ptr got %b want %b", obs, 8'b0010_1_01_0);
        end
        bus.DONE = 1'b1;
        bus.REQ  = 4'b0000;
        @(negedge CLK);
        bus.DONE = 1'b0;
        bus.REQ  = 4'b0011;
        @(negedge CLK);
        obs = snap();
        checks++;
        if (obs !== 8'b0001_1_00_0) begin
            errors++;
            $display("FAIL wd_done_ptr got %b want %b", obs, 8'b0001_1_00_0);
        end
        bus.DONE = 1'b1;
        bus.REQ  = 4'b0000;
        @(negedge CLK);
        bus.DONE = 1'b0;
        obs = snap();
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL idle_end got %b want %b", obs, 8'h00);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] obs;
        bus.REQ = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            obs = snap();
            checks++;
            if (obs !== 8'b0010_1_01_0) begin
                errors++;
                $display("FAIL tmo_wait %0d got %b want %b", i, obs, 8'b0010_1_01_0);
            end
        end
        @(negedge CLK);
        obs = snap();
        checks++;
        if (obs !== 8'b0000_0_00_1) begin
            errors++;
            $display("FAIL tmo_fire got %b want %b", obs, 8'b0000_0_00_1);
        end
        @(negedge CLK);
        obs = snap();
        checks++;
        if (obs !== 8'b0100_1_10_0) begin
            errors++;
            $display("FAIL tmo_next got %b want %b", obs, 8'b0100_1_10_0);
        end
        bus.DONE = 1'b1;
        bus.REQ  = 4'b0000;
        @(negedge CLK);
        bus.DONE = 1'b0;
    endtask
`else
    task automatic test_hold();
        logic [7:0] obs;
        bus.REQ = 4'b0110;
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            obs = snap();
            checks++;
            if (obs !== 8'b0010_1_01_0) begin
                errors++;
                $display("FAIL hold %0d got %b want %b", i, obs, 8'b0010_1_01_0);
            end
        end
        bus.DONE = 1'b1;
        bus.REQ  = 4'b0000;
        @(negedge CLK);
        bus.DONE = 1'b0;
        obs = snap();
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL hold_rel got %b want %b", obs, 8'h00);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rotate();
        test_lock();
        test_withdraw();
        test_async_reset();
        test_idle_done();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_hold();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL time_limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Round-robin arbiter that shares one datapath resource (the shared memory/ALU operand bus built from the std cell library) between NREQ requesters.
- Issues one-hot grants, holds each grant until the resource signals completion, and supports locked back-to-back transfers.
- Sits between the requesting masters (fetch, load/store, DMA) and the resource's control enable.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of GNT_ID; must equal ceil(log2(NREQ))
- TMO_CYCLES, 255, watchdog limit in cycles; used only with ARB_TIMEOUT_EN

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- NRESET  in  1  asynchronous, active-low reset
- REQ  in  NREQ  per-requester request level
- LOCK  in  NREQ  per-requester lock; sampled with DONE
- DONE  in  1  single-cycle pulse from the resource: current transfer complete
- GNT  out  NREQ  one-hot grant, registered
- GNT_VALID  out  1  OR of GNT, registered
- GNT_ID  out  IDW  binary index of the granted requester; 0 when idle
- TIMEOUT  out  1  one-cycle pulse on watchdog release; constant 0 without the feature

Behaviour:
- Reset (NRESET low, asynchronous): state IDLE, GNT=0, GNT_VALID=0, GNT_ID=0, TIMEOUT=0, priority pointer PTR=0.
- FSM states:
  - IDLE: if any REQ bit is set, select the winner as the first set REQ bit searching PTR, PTR+1, ... modulo NREQ. Register GNT/GNT_ID/GNT_VALID and go to BUSY. Latency from REQ to GNT is 1 cycle.
  - BUSY: hold GNT stable. Each cycle:
    - REQ[id]=0 (requester withdrew): release grant next edge, go to IDLE.
    - DONE=1 and LOCK[id]=1 and REQ[id]=1: keep the grant, stay in BUSY (locked burst). PTR is unchanged.
    - DONE=1 otherwise: release grant next edge, go to IDLE, PTR <= (id+1) mod NREQ.
    - Withdrawal and DONE in the same cycle: treat as DONE (PTR advances).
- Turnaround: after a release, GNT_VALID is 0 for exactly one cycle before any new grant. There is never overlap between grants.
- DONE while in IDLE is ignored.
- REQ bits of non-granted requesters have no effect in BUSY.
- PTR wraps from NREQ-1 to 0.
- NRESET asserted mid-transfer drops GNT immediately (asynchronous) and restarts at PTR=0.
- Invariant: GNT is always zero or one-hot, and GNT_ID matches GNT.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and on each locked DONE, and increments each BUSY cycle.
  - When the counter reaches TMO_CYCLES with no DONE, the grant is forced released (go to IDLE, PTR advances as for DONE) and TIMEOUT pulses high for 1 cycle, coincident with GNT dropping.
  - The counter width is derived from TMO_CYCLES.
- Not defined: no counter is built, TIMEOUT is tied 0, and a grant is held indefinitely until DONE or withdrawal.

Decomposition:
- Package arb_pkg holds:
  - state encoding constants (IDLE=1'b0, BUSY=1'b1)
  - the default NREQ/IDW values
  - an onehot-to-index function
- Sub-module rr_pick: purely combinational. Inputs are REQ and PTR; outputs are the one-hot winner, its index, and an any-request flag. It is instantiated once.
- FSM, PTR register and the optional watchdog stay in bus_rr_arbiter.

Test Plan:
- Reset then REQ=4'b0000 for 10 cycles -> GNT=0, GNT_VALID=0, GNT_ID=0 throughout.
- REQ=4'b1111 held, DONE pulsed 2 cycles after each grant -> grants rotate 0,1,2,3,0 with GNT_VALID low for 1 cycle between each grant.
- REQ=4'b0101, LOCK[0]=1, three DONE pulses -> GNT=4'b0001 held across all three. Then LOCK[0]=0 and one more DONE -> next grant is 4'b0100 (PTR=1 skips the idle requester 1).
- Granted requester 2 drops REQ before DONE -> GNT=0 next cycle, PTR unchanged, so requester 2 wins again on re-request if it is the first set bit from PTR.
- NRESET pulsed low while GNT=4'b1000 -> GNT=0 asynchronously. After release with REQ=4'b1000 -> GNT_ID=3 is granted 1 cycle later, searching from PTR=0.
- With ARB_TIMEOUT_EN, TMO_CYCLES=8, grant to 1 and no DONE -> after 8 BUSY cycles TIMEOUT=1 for 1 cycle, GNT=0, then requester 2 is granted if REQ[2]=1.
